// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and helpers for the MiniUart transmitter: FSM state
// encoding, parity and stop-bit codes, and the frame parity function.
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic STOP1 = 1'b0;
  localparam logic STOP2 = 1'b1;

  // True when the parity code selects a parity bit (00 and 11 mean none).
  function automatic logic parity_on(input logic [1:0] par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

  // Parity over the low 5+len bits only; bits above the frame length never
  // contribute. Even parity is the XOR of the data, odd parity its inverse.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic [1:0] len,
                                       input logic [1:0] par);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - len);
    return (^(data & mask)) ^ (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_tx_fifo.sv
// Write FIFO between the CPU store path and the transmit FSM. Register array
// with clocked writes; the head entry is always presented on dout, so a byte
// pushed on one edge is readable in the following cycle.
module tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  // Storage write; entries are only ever read after being written.
  // NOTE: the data array has no reset -- valid entries are tracked by count,
  // so resetting storage would only add reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_tx_fifo.sv
// MiniUart transmitter: DEPTH-entry write FIFO feeding a start/data/parity/
// stop serialiser. One bit time per en_tx tick, framing latched per frame.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_tx,
  input  logic              load,
  input  logic [DATA_W-1:0] d_in,
  input  logic [1:0]        cfg_len,
  input  logic [1:0]        cfg_par,
  input  logic              cfg_stop,
  output logic              txd,
  output logic              ts,
  output logic              full,
  output logic              ovf
);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;

  tx_state_t         state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic              par_bit, par_bit_n;
  logic              txd_q, txd_n;
  logic [1:0]        len_q, len_n;
  logic [1:0]        par_q, par_n;
  logic              stop_q, stop_n;
  logic              stop_first, stop_first_n;
  logic              launch;
  logic              last_bit;

  // A load is accepted when there is room, or when the FSM frees a slot on
  // the same edge; otherwise the byte is lost and ovf records it.
  assign push = load && (!fifo_full || pop);
  assign pop  = launch;

  tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (d_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // The last data bit is on the line when the counter reaches len-1.
  assign last_bit = (bit_cnt == ({1'b0, len_q} + 3'd4));

  // Next-state and next-line computation; nothing moves without en_tx.
  // NOTE: every signal driven here gets its hold value first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    par_bit_n    = par_bit;
    txd_n        = txd_q;
    len_n        = len_q;
    par_n        = par_q;
    stop_n       = stop_q;
    stop_first_n = stop_first;
    launch       = 1'b0;

    if (en_tx) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) launch = 1'b1;
        end
        ST_START: begin
          txd_n     = shreg[0];
          bit_cnt_n = '0;
          state_n   = ST_DATA;
        end
        ST_DATA: begin
          if (last_bit) begin
            if (parity_on(par_q)) begin
              txd_n   = par_bit;
              state_n = ST_PARITY;
            end else begin
              txd_n        = 1'b1;
              stop_first_n = 1'b1;
              state_n      = ST_STOP;
            end
          end else begin
            shreg_n   = shreg >> 1;
            txd_n     = shreg[1];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          txd_n        = 1'b1;
          stop_first_n = 1'b1;
          state_n      = ST_STOP;
        end
        ST_STOP: begin
          if (stop_q == STOP2 && stop_first) begin
            txd_n        = 1'b1;
            stop_first_n = 1'b0;
          end else if (!fifo_empty) begin
            launch = 1'b1;
          end else begin
            txd_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
        default: begin
          txd_n   = 1'b1;
          state_n = ST_IDLE;
        end
      endcase
    end

    // Frame start, from IDLE or back-to-back from STOP: take the head byte
    // and freeze the framing so later cfg_* changes wait for the next frame.
    if (launch) begin
      shreg_n      = fifo_dout;
      len_n        = cfg_len;
      par_n        = cfg_par;
      stop_n       = cfg_stop;
      par_bit_n    = calc_parity(fifo_dout, cfg_len, cfg_par);
      stop_first_n = 1'b0;
      txd_n        = 1'b0;
      state_n      = ST_START;
    end
  end

  // Serialiser registers; reset parks the line high in IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      txd_q      <= 1'b1;
      len_q      <= '0;
      par_q      <= PAR_NONE;
      stop_q     <= STOP1;
      stop_first <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      par_bit    <= par_bit_n;
      txd_q      <= txd_n;
      len_q      <= len_n;
      par_q      <= par_n;
      stop_q     <= stop_n;
      stop_first <= stop_first_n;
    end
  end

  // Sticky overflow: a load that found the FIFO full with no pop to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (load && fifo_full && !pop) ovf <= 1'b1;
  end

  assign txd  = txd_q;
  assign full = fifo_full;
  assign ts   = (state == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A line-level reference model keeps a
// byte queue for the FIFO and a bit queue for the frame on the wire; every
// clock the DUT's txd, ts, full and ovf are compared against it.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       en_tx;
  logic       load;
  logic [7:0] d_in;
  logic [1:0] cfg_len;
  logic [1:0] cfg_par;
  logic       cfg_stop;
  logic       txd;
  logic       ts;
  logic       full;
  logic       ovf;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_tx    (en_tx),
    .load     (load),
    .d_in     (d_in),
    .cfg_len  (cfg_len),
    .cfg_par  (cfg_par),
    .cfg_stop (cfg_stop),
    .txd      (txd),
    .ts       (ts),
    .full     (full),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp;
  int    n_err;
  int    cyc;
  string cur_test;

  // Reference model state.
  logic [7:0] m_fifo[$];
  logic       m_bits[$];
  logic       m_txd;
  bit         m_busy;
  bit         m_ovf;

  // Expand a byte into the exact bit sequence seen on the line, using the
  // configuration present at the moment the frame starts.
  task automatic build_frame(input logic [7:0] b);
    int   len;
    logic p;
    len = 5 + int'(cfg_len);
    p   = 1'b0;
    m_bits.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      m_bits.push_back(b[i]);
      p = p ^ b[i];
    end
    if (cfg_par == 2'b01) m_bits.push_back(p);
    if (cfg_par == 2'b10) m_bits.push_back(~p);
    m_bits.push_back(1'b1);
    if (cfg_stop) m_bits.push_back(1'b1);
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_bits.delete();
    m_txd  = 1'b1;
    m_busy = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic ld, input logic [7:0] d, input logic tk);
    logic exp_ts;
    logic exp_full;
    load  = ld;
    d_in  = d;
    en_tx = tk;
    if (tk) begin
      if (m_bits.size() == 0 && m_fifo.size() > 0) build_frame(m_fifo.pop_front());
      if (m_bits.size() > 0) begin
        m_txd  = m_bits.pop_front();
        m_busy = 1'b1;
      end else begin
        m_txd  = 1'b1;
        m_busy = 1'b0;
      end
    end
    if (ld) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
      else m_ovf = 1'b1;
    end
    exp_ts   = !m_busy && (m_fifo.size() == 0);
    exp_full = (m_fifo.size() == DEPTH);
    @(posedge clk);
    #1;
    load  = 1'b0;
    en_tx = 1'b0;
    cyc++;
    n_cmp++;
    if (txd !== m_txd) begin
      n_err++;
      $display("FAIL %s txd cyc %0d: got %b want %b", cur_test, cyc, txd, m_txd);
    end
    n_cmp++;
    if (ts !== exp_ts) begin
      n_err++;
      $display("FAIL %s ts cyc %0d: got %b want %b", cur_test, cyc, ts, exp_ts);
    end
    n_cmp++;
    if (full !== exp_full) begin
      n_err++;
      $display("FAIL %s full cyc %0d: got %b want %b", cur_test, cyc, full, exp_full);
    end
    n_cmp++;
    if (ovf !== m_ovf) begin
      n_err++;
      $display("FAIL %s ovf cyc %0d: got %b want %b", cur_test, cyc, ovf, m_ovf);
    end
  endtask

  task automatic tick_gap(input int gap);
    repeat (gap - 1) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  // Tick until the model says the line is drained, with a bounded budget.
  task automatic drain(input int gap);
    int guard;
    guard = 0;
    while ((m_fifo.size() > 0 || m_busy) && guard < 400) begin
      tick_gap(gap);
      guard++;
    end
    n_cmp++;
    if (guard >= 400) begin
      n_err++;
      $display("FAIL %s drain timeout: got busy want idle", cur_test);
    end
  endtask

  task automatic set_cfg(input logic [1:0] len, input logic [1:0] par, input logic stp);
    cfg_len  = len;
    cfg_par  = par;
    cfg_stop = stp;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    do_reset();
    n_cmp++;
    if ({txd, ts, full, ovf} !== 4'b1100) begin
      n_err++;
      $display("FAIL reset outputs: got %b want 1100", {txd, ts, full, ovf});
    end
    // Ticks with an empty FIFO must leave the line untouched.
    repeat (5) tick_gap(3);
  endtask

  task automatic test_8n1();
    logic [9:0] seq;
    cur_test = "8n1";
    set_cfg(2'd3, 2'b00, 1'b0);
    seq = '0;
    cycle(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick_gap(16);
      seq = {seq[8:0], txd};
    end
    n_cmp++;
    if (seq !== 10'b0101001011) begin
      n_err++;
      $display("FAIL 8n1 line sequence: got %b want 0101001011", seq);
    end
    drain(16);
  endtask

  task automatic test_parity();
    logic [7:0] seq;
    cur_test = "7e2";
    set_cfg(2'd2, 2'b01, 1'b1);
    cycle(1'b1, 8'hFF, 1'b0);
    drain(4);
    cur_test = "7o2";
    set_cfg(2'd2, 2'b10, 1'b1);
    cycle(1'b1, 8'hFF, 1'b0);
    drain(4);
    cur_test = "5o1";
    set_cfg(2'd0, 2'b10, 1'b0);
    seq = '0;
    cycle(1'b1, 8'hE3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick_gap(3);
      seq = {seq[6:0], txd};
    end
    n_cmp++;
    if (seq !== 8'b01100011) begin
      n_err++;
      $display("FAIL 5o1 line sequence: got %b want 01100011", seq);
    end
    drain(3);
  endtask

  task automatic test_back_to_back();
    cur_test = "b2b";
    set_cfg(2'd3, 2'b00, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    drain(4);
  endtask

  task automatic test_overflow();
    cur_test = "ovf";
    set_cfg(2'd3, 2'b01, 1'b0);
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h82, 1'b0);
    cycle(1'b1, 8'h43, 1'b0);
    cycle(1'b1, 8'hC4, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    drain(2);
  endtask

  task automatic test_reset_mid();
    cur_test = "rst_mid";
    do_reset();
    set_cfg(2'd3, 2'b00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    repeat (4) tick_gap(4);
    cycle(1'b0, 8'h00, 1'b0);
    // Assert reset between edges; the outputs must respond without a clock.
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({txd, ts} !== 2'b11) begin
      n_err++;
      $display("FAIL rst_mid async: got txd,ts=%b want 11", {txd, ts});
    end
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) tick_gap(2);
    cycle(1'b1, 8'h5A, 1'b0);
    drain(3);
  endtask

  task automatic test_random();
    logic ld;
    logic tk;
    cur_test = "random";
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0)
        set_cfg(2'($urandom), 2'($urandom), 1'($urandom));
      ld = ($urandom_range(0, 5) == 0);
      tk = ($urandom_range(0, 2) == 0);
      cycle(ld, 8'($urandom), tk);
    end
    drain(3);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    en_tx    = 1'b0;
    load     = 1'b0;
    d_in     = '0;
    cfg_len  = 2'd3;
    cfg_par  = 2'b00;
    cfg_stop = 1'b0;
    model_clear();
    #2;
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
